meteor_field: RTL and testbench
===============================

# meteor_field

Owns the falling-meteor population for the meteor-dodge game: spawns meteors at pseudo-random columns, moves them down once per video frame, retires them at the bottom edge and freezes the field when the collision detector reports a hit. Its `meteor_x`/`meteor_y`/`meteor_active` outputs drive the collision detector and renderer directly. The detector's `meteor_collisions` vector is fed back as an input. Sits between the frame-timing logic (VGA vblank pulse) and the game-control FSM.

## Interface
- `NUM_METEORS`, 6: meteor slots.
- `METEOR_SIZE`, 30: square meteor edge, px.
- `SCREEN_W`, 640: visible width, px.
- `SCREEN_H`, 480: visible height, px.
- `SPEED`, 2: downward px per frame, 1..31.
- `SPAWN_PERIOD`, 45: frames between spawn attempts, ≥1.
- `LFSR_SEED`, 10'h2A5: non-zero LFSR reset value.

Ports:
- `clk` in 1: single clock; all state in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame (vblank).
- `enable` in 1: start request from game control.
- `clear` in 1: synchronous restart to IDLE.
- `meteor_collisions` in NUM_METEORS: per-slot hit flags from the collision detector.
- `meteor_x` out 10 × NUM_METEORS: top-left x per slot.
- `meteor_y` out 9 × NUM_METEORS: top-left y per slot.
- `meteor_active` out NUM_METEORS: slot valid.
- `game_over` out 1: high in HALT.
- `hit_mask` out NUM_METEORS: latched `meteor_collisions & meteor_active` at the hit.
- `dodged_count` out 8: meteors retired at the bottom edge, saturating at 255.

## Operation
- FSM states are IDLE, RUN and HALT. Reset and `clear` both go to IDLE. `clear` has priority over every other input in every state.
- IDLE: all slots parked (x=700, y=500, inactive). `dodged_count`=0, `hit_mask`=0, spawn counter=0. Go to RUN when `enable`=1.
- RUN: a collision is `|(meteor_collisions & meteor_active)`, evaluated every cycle.
  - Collision → HALT next cycle. `hit_mask` latches the masked vector. Positions and active bits stay frozen, and the hit meteor remains visible.
  - Otherwise, on `frame_tick`, perform in order:
    1. Move: each active slot gets `y' = y + SPEED`, computed at 10 bits.
    2. Retire: if `y' ≥ SCREEN_H`, the slot parks and goes inactive. `dodged_count` increases by the number retired this tick, saturating.
    3. Spawn: if the spawn counter equals `SPAWN_PERIOD-1`, the counter goes to 0 and the lowest-indexed slot that was inactive before this tick gets y=0 and x=`lfsr mod (SCREEN_W-METEOR_SIZE)`. Otherwise the counter increments.
  - A slot retired in the same tick is not reused for the spawn.
  - With no free slot, the spawn is skipped and the counter still wraps.
  - A newly spawned meteor does not move on its spawn tick.
- HALT: ignores `frame_tick` and `enable`. Only `clear` exits.
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1. Advances every cycle in every state, including IDLE and HALT. It never holds 0.
- Modulo: x = lfsr if `lfsr < 610`, else `lfsr − 610`. One compare and one subtract suffice for the defaults.

## Timing
- Reset values: every slot x=700, y=500, `meteor_active`=0, `game_over`=0, `hit_mask`=0, `dodged_count`=0, state IDLE, LFSR=`LFSR_SEED`.
- All outputs are registered. Frame updates are visible the cycle after `frame_tick`.
- `game_over` and `hit_mask` update the cycle after the collision input is sampled.
- Collision and `frame_tick` in the same cycle: collision wins and no move happens.
- `clear` and collision in the same cycle: `clear` wins.
- `reset_n` low mid-RUN restores the reset values immediately, asynchronously.
- `enable` and `frame_tick` in the same cycle while in IDLE: the tick is not processed.

## Structure
- `meteor_pkg` holds:
  - state enum (IDLE/RUN/HALT);
  - `PARK_X`=700 and `PARK_Y`=500;
  - screen and meteor size constants shared with the collision detector and renderer.
- Sub-module `meteor_lfsr` provides the seeded 10-bit LFSR with a free-running step.
- Per-slot move, retire and spawn logic is a generate loop inside `meteor_field`. Lowest-free-slot selection is a priority encoder.

## Test plan
- **Reset/idle:** `reset_n`=0 then 1 → all x=700, y=500, active=000000, `dodged_count`=0. Ten `frame_tick`s in IDLE change nothing.
- **Spawn/move** (`SPAWN_PERIOD`=4, `SPEED`=2): `enable`, then four ticks → active=000001, y[0]=0, x[0] matches the LFSR reference model and is <610. The fifth tick gives y[0]=2.
- **Retire** (`SPEED`=16): after spawn, the 29th move gives y[0]=464. The 30th retires it → active bit 0 clears, x/y=700/500, `dodged_count`=1.
- **Full field:** six spawns fill the slots → active=111111. The seventh spawn is skipped and the counter wraps.
- **Collision:** slot 1 active and `meteor_collisions`=000010 coincident with `frame_tick` → next cycle `game_over`=1, `hit_mask`=000010, positions unchanged. Further ticks change nothing.
- **Clear:** `clear` from HALT → IDLE, all parked, `game_over`=0, `dodged_count`=0. Asserting `reset_n` low mid-RUN yields the same outputs.

Source files
------------

// File: rtl/meteor_pkg.sv
// Shared types and screen geometry for the meteor-dodge playfield.
// The collision detector and renderer import the same constants.
package meteor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } field_state_t;

  localparam logic [9:0] PARK_X = 10'd700;
  localparam logic [8:0] PARK_Y = 9'd500;

  localparam int SCREEN_W_PX    = 640;
  localparam int SCREEN_H_PX    = 480;
  localparam int METEOR_SIZE_PX = 30;

  // Values below 2*span need only one compare and one subtract to reduce.
  function automatic logic [9:0] wrap_x(input logic [9:0] value, input logic [9:0] span);
    return (value < span) ? value : value - span;
  endfunction

endpackage

// File: rtl/meteor_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1), stepping every cycle.
// A non-zero seed keeps it out of the all-zero lock-up state.
module meteor_lfsr #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] lfsr
);

  logic [9:0] lfsr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
    end
  end

  assign lfsr = lfsr_reg;

endmodule

// File: rtl/meteor_field.sv
// Falling-meteor population: spawns, moves and retires meteors once per frame,
// and freezes the field when the collision detector reports a hit.
module meteor_field
  import meteor_pkg::*;
#(
  parameter int         NUM_METEORS  = 6,
  parameter int         METEOR_SIZE  = METEOR_SIZE_PX,
  parameter int         SCREEN_W     = SCREEN_W_PX,
  parameter int         SCREEN_H     = SCREEN_H_PX,
  parameter int         SPEED        = 2,
  parameter int         SPAWN_PERIOD = 45,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_tick,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [NUM_METEORS-1:0]       meteor_collisions,
  output logic [NUM_METEORS-1:0][9:0]  meteor_x,
  output logic [NUM_METEORS-1:0][8:0]  meteor_y,
  output logic [NUM_METEORS-1:0]       meteor_active,
  output logic                         game_over,
  output logic [NUM_METEORS-1:0]       hit_mask,
  output logic [7:0]                   dodged_count
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int RC_W  = $clog2(NUM_METEORS + 1);

  localparam logic [CNT_W-1:0] SPAWN_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [9:0]       X_SPAN     = 10'(SCREEN_W - METEOR_SIZE);
  localparam logic [9:0]       Y_STEP     = 10'(SPEED);
  localparam logic [9:0]       Y_LIMIT    = 10'(SCREEN_H);

  field_state_t           state_reg;
  logic [CNT_W-1:0]       spawn_cnt_reg;
  logic [7:0]             dodged_count_reg;
  logic                   game_over_reg;
  logic [NUM_METEORS-1:0] hit_mask_reg;

  logic [9:0]             lfsr;
  logic [9:0]             spawn_x;
  logic [NUM_METEORS-1:0] active_vec;
  logic [NUM_METEORS-1:0] retire_vec;
  logic [NUM_METEORS-1:0] spawn_sel;
  logic [NUM_METEORS-1:0] free_below;
  logic [NUM_METEORS-1:0] hit_vec;
  logic                   collision;
  logic                   do_tick;
  logic                   do_spawn;
  logic                   park_all;
  logic [RC_W-1:0]        retire_cnt;
  logic [8:0]             dodged_sum;
  logic [7:0]             dodged_next;

  meteor_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .lfsr    (lfsr)
  );

  assign hit_vec   = meteor_collisions & active_vec;
  assign collision = |hit_vec;
  // A hit in the same cycle as a frame tick suppresses the frame update.
  assign do_tick   = (state_reg == ST_RUN) && frame_tick && !collision && !clear;
  assign do_spawn  = do_tick && (spawn_cnt_reg == SPAWN_LAST);
  assign park_all  = clear || (state_reg == ST_IDLE);
  assign spawn_x   = wrap_x(lfsr, X_SPAN);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_METEORS; gi++) begin : g_slot
      logic [9:0] x_reg;
      logic [8:0] y_reg;
      logic       active_reg;
      logic [9:0] y_sum;

      // Priority encoder: this slot is chosen only if no lower slot is free.
      if (gi == 0) begin : g_first
        assign free_below[gi] = 1'b0;
      end else begin : g_rest
        assign free_below[gi] = free_below[gi-1] | ~active_vec[gi-1];
      end
      assign spawn_sel[gi] = ~active_vec[gi] & ~free_below[gi];

      assign y_sum          = {1'b0, y_reg} + Y_STEP;
      assign retire_vec[gi] = active_reg && (y_sum >= Y_LIMIT);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_reg      <= PARK_X;
          y_reg      <= PARK_Y;
          active_reg <= 1'b0;
        end else if (park_all) begin
          x_reg      <= PARK_X;
          y_reg      <= PARK_Y;
          active_reg <= 1'b0;
        end else if (do_tick) begin
          if (active_reg) begin
            if (retire_vec[gi]) begin
              x_reg      <= PARK_X;
              y_reg      <= PARK_Y;
              active_reg <= 1'b0;
            end else begin
              y_reg <= y_sum[8:0];
            end
          end else if (do_spawn && spawn_sel[gi]) begin
            x_reg      <= spawn_x;
            y_reg      <= 9'd0;
            active_reg <= 1'b1;
          end
        end
      end

      assign active_vec[gi] = active_reg;
      assign meteor_x[gi]   = x_reg;
      assign meteor_y[gi]   = y_reg;
    end
  endgenerate

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_METEORS; i++) begin
      retire_cnt = retire_cnt + RC_W'(retire_vec[i]);
    end
  end

  assign dodged_sum  = {1'b0, dodged_count_reg} + 9'(retire_cnt);
  assign dodged_next = dodged_sum[8] ? 8'hFF : dodged_sum[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      spawn_cnt_reg    <= '0;
      dodged_count_reg <= 8'd0;
      game_over_reg    <= 1'b0;
      hit_mask_reg     <= '0;
    end else if (clear) begin
      state_reg        <= ST_IDLE;
      spawn_cnt_reg    <= '0;
      dodged_count_reg <= 8'd0;
      game_over_reg    <= 1'b0;
      hit_mask_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          spawn_cnt_reg    <= '0;
          dodged_count_reg <= 8'd0;
          game_over_reg    <= 1'b0;
          hit_mask_reg     <= '0;
          if (enable) begin
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (collision) begin
            state_reg     <= ST_HALT;
            game_over_reg <= 1'b1;
            hit_mask_reg  <= hit_vec;
          end else if (do_tick) begin
            dodged_count_reg <= dodged_next;
            spawn_cnt_reg    <= do_spawn ? '0 : spawn_cnt_reg + CNT_W'(1);
          end
        end
        ST_HALT: begin
          game_over_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign meteor_active = active_vec;
  assign game_over     = game_over_reg;
  assign hit_mask      = hit_mask_reg;
  assign dodged_count  = dodged_count_reg;

endmodule

// File: tb/tb_meteor_field.sv
// Directed bench for meteor_field: two instances (slow and fast fall) share
// stimulus; expected values are hand-derived plus a reference LFSR.
`timescale 1ns/1ps
module tb_meteor_field;

  logic clk = 1'b0;
  logic reset_n;
  logic frame_tick;
  logic enable;
  logic clear;
  logic [5:0] a_coll;
  logic [5:0] b_coll;

  logic [5:0][9:0] a_x, b_x;
  logic [5:0][8:0] a_y, b_y;
  logic [5:0]      a_active, b_active;
  logic            a_game_over, b_game_over;
  logic [5:0]      a_hit, b_hit;
  logic [7:0]      a_dodged, b_dodged;

  logic [9:0] ref_lfsr;
  logic [9:0] tick_lfsr;
  logic [59:0] park_x_all;
  logic [53:0] park_y_all;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;

  always #5 clk = ~clk;

  meteor_field #(
    .SPEED        (2),
    .SPAWN_PERIOD (4)
  ) dut_a (
    .clk               (clk),
    .reset_n           (reset_n),
    .frame_tick        (frame_tick),
    .enable            (enable),
    .clear             (clear),
    .meteor_collisions (a_coll),
    .meteor_x          (a_x),
    .meteor_y          (a_y),
    .meteor_active     (a_active),
    .game_over         (a_game_over),
    .hit_mask          (a_hit),
    .dodged_count      (a_dodged)
  );

  meteor_field #(
    .SPEED        (16),
    .SPAWN_PERIOD (4)
  ) dut_b (
    .clk               (clk),
    .reset_n           (reset_n),
    .frame_tick        (frame_tick),
    .enable            (enable),
    .clear             (clear),
    .meteor_collisions (b_coll),
    .meteor_x          (b_x),
    .meteor_y          (b_y),
    .meteor_active     (b_active),
    .game_over         (b_game_over),
    .hit_mask          (b_hit),
    .dodged_count      (b_dodged)
  );

  // Reference LFSR; tick_lfsr holds the value seen in the last frame_tick cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_lfsr  <= 10'h2A5;
      tick_lfsr <= 10'h000;
    end else begin
      if (frame_tick) tick_lfsr <= ref_lfsr;
      ref_lfsr <= {ref_lfsr[8:0], ref_lfsr[9] ^ ref_lfsr[6]};
    end
  end

  function automatic logic [9:0] ref_x(input logic [9:0] v);
    return (v < 10'd610) ? v : v - 10'd610;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    ticks++;
  endtask

  task automatic pulse_enable();
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
  endtask

  initial begin
    park_x_all = {6{10'd700}};
    park_y_all = {6{9'd500}};
    reset_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; clear = 1'b0;
    a_coll = 6'd0; b_coll = 6'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    check("reset_active", a_active, 6'd0);
    check("reset_x", a_x, park_x_all);
    check("reset_y", a_y, park_y_all);
    check("reset_dodged", a_dodged, 8'd0);
    check("reset_game_over", a_game_over, 1'b0);
    check("reset_hit_mask", a_hit, 6'd0);

    repeat (10) tick();
    check("idle_active", a_active, 6'd0);
    check("idle_x", a_x, park_x_all);
    check("idle_y", a_y, park_y_all);
    check("idle_b_active", b_active, 6'd0);

    pulse_enable();
    ticks = 0;
    repeat (3) tick();
    check("pre_spawn_active", a_active, 6'd0);
    tick();
    check("spawn_active", a_active, 6'b000001);
    check("spawn_y0", a_y[0], 9'd0);
    check("spawn_x0", a_x[0], ref_x(tick_lfsr));
    check("spawn_x0_range", (a_x[0] < 10'd610), 1'b1);
    check("spawn_b_x0", b_x[0], ref_x(tick_lfsr));
    tick();
    check("move_y0", a_y[0], 9'd2);
    check("move_b_y0", b_y[0], 9'd16);

    while (ticks < 24) tick();
    check("full_active", a_active, 6'b111111);
    while (ticks < 28) tick();
    check("skip_active", a_active, 6'b111111);
    check("skip_y5", a_y[5], 9'd8);

    while (ticks < 33) tick();
    check("pre_retire_y0", b_y[0], 9'd464);
    check("pre_retire_active", b_active, 6'b111111);
    check("pre_retire_dodged", b_dodged, 8'd0);
    tick();
    check("retire_active", b_active, 6'b111110);
    check("retire_x0", b_x[0], 10'd700);
    check("retire_y0", b_y[0], 9'd500);
    check("retire_dodged", b_dodged, 8'd1);
    check("retire_y1", b_y[1], 9'd416);
    while (ticks < 36) tick();
    check("wrap_respawn_active", b_active, 6'b111111);
    check("wrap_respawn_y0", b_y[0], 9'd0);
    check("wrap_respawn_x0", b_x[0], ref_x(tick_lfsr));

    check("pre_hit_y0", a_y[0], 9'd64);
    @(posedge clk); #1 frame_tick = 1'b1; a_coll = 6'b000010;
    @(posedge clk); #1 frame_tick = 1'b0; a_coll = 6'd0;
    ticks++;
    check("hit_game_over", a_game_over, 1'b1);
    check("hit_mask", a_hit, 6'b000010);
    check("hit_y0", a_y[0], 9'd64);
    check("hit_y1", a_y[1], 9'd56);
    check("hit_active", a_active, 6'b111111);
    check("hit_b_game_over", b_game_over, 1'b0);
    repeat (3) tick();
    check("halt_y0", a_y[0], 9'd64);
    check("halt_y5", a_y[5], 9'd24);
    check("halt_game_over", a_game_over, 1'b1);
    check("halt_b_dodged", b_dodged, 8'd2);
    pulse_enable();
    check("halt_enable_ignored", a_game_over, 1'b1);

    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    check("clear_game_over", a_game_over, 1'b0);
    check("clear_active", a_active, 6'd0);
    check("clear_x", a_x, park_x_all);
    check("clear_y", a_y, park_y_all);
    check("clear_hit_mask", a_hit, 6'd0);
    check("clear_b_dodged", b_dodged, 8'd0);

    // enable with a coincident tick: the tick is not counted toward a spawn
    @(posedge clk); #1 enable = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 enable = 1'b0; frame_tick = 1'b0;
    repeat (3) tick();
    check("en_tick_active", a_active, 6'd0);
    tick();
    check("en_tick_spawn", a_active, 6'b000001);
    check("en_tick_x0", a_x[0], ref_x(tick_lfsr));
    tick();
    check("en_tick_move", a_y[0], 9'd2);

    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    check("areset_active", a_active, 6'd0);
    check("areset_x", a_x, park_x_all);
    check("areset_y", a_y, park_y_all);
    check("areset_dodged", a_dodged, 8'd0);
    check("areset_game_over", a_game_over, 1'b0);
    check("areset_b_active", b_active, 6'd0);
    #10 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
